// File: rtl/tick_sequencer_pkg.sv
// Shared constants for the tick sequencer and the 3x2 grid top: FSM encoding, period floor, defaults.
// No logic; pure declarations.
package tick_sequencer_pkg;

    localparam int NUM_CORES_DEFAULT  = 6;
    localparam int PERIOD_W_DEFAULT   = 24;
    localparam int TICK_CNT_W_DEFAULT = 16;

    // Shortest period that still fits ISSUE, one WAIT_DONE cycle and one WAIT_PERIOD cycle.
    localparam int MIN_PERIOD = 3;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ISSUE       = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE   = 3'd2;
    localparam logic [2:0] ST_WAIT_PERIOD = 3'd3;
    localparam logic [2:0] ST_FINISH      = 3'd4;

    typedef enum logic [2:0] {
        IDLE        = ST_IDLE,
        ISSUE       = ST_ISSUE,
        WAIT_DONE   = ST_WAIT_DONE,
        WAIT_PERIOD = ST_WAIT_PERIOD,
        FINISH      = ST_FINISH
    } state_t;

endpackage

// File: rtl/tick_sequencer_if.sv
// Control, status and core tick/done/error bundle of the tick sequencer.
// master = the sequencer (tick initiator); slave = run controller plus grid controllers.
interface tick_sequencer_if
    import tick_sequencer_pkg::*;
#(
    parameter int NUM_CORES  = NUM_CORES_DEFAULT,
    parameter int PERIOD_W   = PERIOD_W_DEFAULT,
    parameter int TICK_CNT_W = TICK_CNT_W_DEFAULT
);
    logic                  start;
    logic                  stop;
    logic [PERIOD_W-1:0]   period;
    logic [TICK_CNT_W-1:0] num_ticks;
    logic [NUM_CORES-1:0]  core_done;
    logic [NUM_CORES-1:0]  core_error;

    logic                  tick;
    logic                  busy;
    logic                  frame_done;
    logic                  finished;
    logic                  overrun;
    logic [NUM_CORES-1:0]  error_flags;
    logic [TICK_CNT_W-1:0] tick_count;

    modport master (
        input  start, stop, period, num_ticks, core_done, core_error,
        output tick, busy, frame_done, finished, overrun, error_flags, tick_count
    );

    modport slave (
        output start, stop, period, num_ticks, core_done, core_error,
        input  tick, busy, frame_done, finished, overrun, error_flags, tick_count
    );

endinterface

// File: rtl/tick_sequencer_done_collector.sv
// Sticky per-core done mask; all_done also counts this cycle's core_done so completion is seen without delay.
// Latency 0 for all_done; the mask itself updates on the next edge. No backpressure.
module tick_sequencer_done_collector
    import tick_sequencer_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 all_done
);

    logic [NUM_CORES-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mask_q <= '0;
        end else if (enable) begin
            mask_q <= mask_q | core_done;
        end
    end

    assign all_done = &(mask_q | core_done);

endmodule

// File: rtl/tick_sequencer.sv
// Issues periodic one-cycle ticks to the grid controllers, holds the next tick until every core reports done.
// Tick lands exactly `period` cycles apart, or 2 cycles after the completing done of a late frame.
module tick_sequencer
    import tick_sequencer_pkg::*;
#(
    parameter int NUM_CORES  = NUM_CORES_DEFAULT,
    parameter int PERIOD_W   = PERIOD_W_DEFAULT,
    parameter int TICK_CNT_W = TICK_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    tick_sequencer_if.master  bus
);

    state_t                state_q;
    state_t                state_d;

    logic [PERIOD_W-1:0]   period_q;
    logic [PERIOD_W-1:0]   cnt_q;
    logic [TICK_CNT_W-1:0] num_q;
    logic [TICK_CNT_W-1:0] count_q;
    logic                  overrun_q;
    logic                  stop_req_q;
    logic [NUM_CORES-1:0]  err_q;

    logic                  all_done;
    logic                  cnt_zero;
    logic                  last_frame;
    logic                  mask_clear;
    logic                  mask_en;
    logic                  tick;
    logic                  frame_done;
    logic                  finished;
    logic [PERIOD_W-1:0]   period_eff;
    logic [TICK_CNT_W-1:0] count_inc;

    tick_sequencer_done_collector #(
        .NUM_CORES (NUM_CORES)
    ) u_done_collector (
        .clk       (clk),
        .reset     (reset),
        .clear     (mask_clear),
        .enable    (mask_en),
        .core_done (bus.core_done),
        .all_done  (all_done)
    );

    assign period_eff = (bus.period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : bus.period;
    assign cnt_zero   = (cnt_q == '0);
    assign count_inc  = count_q + TICK_CNT_W'(1);
    // A stop arriving in the completing cycle still ends the run at this boundary.
    assign last_frame = stop_req_q || bus.stop || ((num_q != '0) && (count_inc == num_q));

    always_comb begin
        state_d    = state_q;
        tick       = 1'b0;
        frame_done = 1'b0;
        finished   = 1'b0;
        mask_clear = 1'b0;
        mask_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tick       = 1'b1;
                mask_clear = 1'b1;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                mask_en = 1'b1;
                if (all_done) begin
                    frame_done = 1'b1;
                    state_d    = last_frame ? FINISH : WAIT_PERIOD;
                end
            end
            WAIT_PERIOD: begin
                if (cnt_zero) begin
                    state_d = ISSUE;
                end
            end
            FINISH: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            period_q   <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            stop_req_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE) begin
                if (bus.start) begin
                    period_q   <= period_eff;
                    num_q      <= bus.num_ticks;
                    count_q    <= '0;
                    overrun_q  <= 1'b0;
                    stop_req_q <= 1'b0;
                    err_q      <= '0;
                end
            end else begin
                err_q <= err_q | bus.core_error;
                if (bus.stop) begin
                    stop_req_q <= 1'b1;
                end
            end

            // Counter reads 0 in the last cycle before the next tick is due.
            if (state_q == ISSUE) begin
                cnt_q <= period_q - PERIOD_W'(2);
            end else if ((state_q == WAIT_DONE || state_q == WAIT_PERIOD) && !cnt_zero) begin
                cnt_q <= cnt_q - PERIOD_W'(1);
            end

            if (frame_done) begin
                count_q <= count_inc;
            end

            if (state_q == WAIT_DONE && !all_done && cnt_zero) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.tick        = tick;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = frame_done;
    assign bus.finished    = finished;
    assign bus.overrun     = overrun_q;
    assign bus.error_flags = err_q;
    assign bus.tick_count  = count_q;

endmodule
